// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end.
// Holds the fetch PC and keeps at most one read outstanding to instruction memory
// (req/ack). Returned words are queued with their PCs in a small circular FIFO and
// presented to decode with a valid/ready handshake. Supports branch redirect (flush,
// discard of an in-flight read) and halt (no new reads).
//
// Ports:
//   clk                clock, rising edge
//   rst                synchronous active-low reset
//   i_halt             suppress new fetch requests
//   i_redirect_valid   branch taken: flush and refetch from i_redirect_addr
//   i_redirect_addr    branch target
//   o_mem_req          read request (registered)
//   o_mem_addr         read address (registered, stable while o_mem_req)
//   i_mem_ack          one-cycle completion pulse, i_mem_rdata valid with it
//   i_mem_rdata        fetched instruction
//   o_if_valid         buffer head valid
//   o_if_inst          head instruction
//   o_if_pc            head PC
//   i_if_ready         decode accepts head when o_if_valid && i_if_ready
module inst_fetch_unit #(
  parameter int unsigned INST_ADDR_WIDTH   = 16,
  parameter int unsigned INST_WIDTH        = 16,
  parameter int unsigned NUM_BYTES_IN_INST = 2,
  parameter int unsigned BUF_DEPTH         = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_halt,
  input  logic                       i_redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] i_redirect_addr,
  output logic                       o_mem_req,
  output logic [INST_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                       i_mem_ack,
  input  logic [INST_WIDTH-1:0]      i_mem_rdata,
  output logic                       o_if_valid,
  output logic [INST_WIDTH-1:0]      o_if_inst,
  output logic [INST_ADDR_WIDTH-1:0] o_if_pc,
  input  logic                       i_if_ready
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                     r_state;
  logic [INST_ADDR_WIDTH-1:0] r_fetch_pc;
  logic                       r_mem_req;
  logic [INST_ADDR_WIDTH-1:0] r_mem_addr;
  logic                       r_discard;
  logic [PtrW-1:0]            r_head;
  logic [PtrW-1:0]            r_tail;
  logic [CntW-1:0]            r_count;
  logic [INST_WIDTH-1:0]      r_buf_inst [BUF_DEPTH];
  logic [INST_ADDR_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
  logic [INST_WIDTH-1:0]      r_if_inst;
  logic [INST_ADDR_WIDTH-1:0] r_if_pc;

  logic                       w_ack;
  logic                       w_pop;
  logic                       w_push;
  logic [CntW-1:0]            w_count_next;
  logic                       w_issue;
  logic [INST_ADDR_WIDTH-1:0] w_fetch_pc_next;
  logic [PtrW-1:0]            w_head_next;
  logic [PtrW-1:0]            w_tail_next;
  logic                       w_head_load;
  logic [INST_WIDTH-1:0]      w_head_inst;
  logic [INST_ADDR_WIDTH-1:0] w_head_pc;

  always_comb begin
    w_ack  = (r_state == StWait) && i_mem_ack;
    // Redirect takes priority: it flushes the buffer, so neither pop nor push happen.
    w_pop  = (r_count != '0) && i_if_ready && !i_redirect_valid;
    w_push = w_ack && !r_discard && !i_redirect_valid;

    w_count_next = i_redirect_valid ? '0 : r_count + CntW'(w_push) - CntW'(w_pop);
    // A request is only issued if its data is guaranteed a free slot.
    w_issue      = !i_halt && (w_count_next < CntW'(BUF_DEPTH));

    if (i_redirect_valid) begin
      w_fetch_pc_next = i_redirect_addr;
    end else if (w_push) begin
      w_fetch_pc_next = r_mem_addr + INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);
    end else begin
      w_fetch_pc_next = r_fetch_pc;
    end

    w_head_next = r_head;
    w_tail_next = r_tail;
    if (i_redirect_valid) begin
      w_tail_next = r_head;
    end else begin
      if (w_pop)  w_head_next = r_head + PtrW'(1);
      if (w_push) w_tail_next = r_tail + PtrW'(1);
    end

    // Next head entry may be the word being written this very edge.
    w_head_load = (w_count_next != '0);
    if (w_push && (r_tail == w_head_next)) begin
      w_head_inst = i_mem_rdata;
      w_head_pc   = r_mem_addr;
    end else begin
      w_head_inst = r_buf_inst[w_head_next];
      w_head_pc   = r_buf_pc[w_head_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_fetch_pc <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_discard  <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_if_inst  <= '0;
      r_if_pc    <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        r_buf_inst[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      r_fetch_pc <= w_fetch_pc_next;
      r_head     <= w_head_next;
      r_tail     <= w_tail_next;
      r_count    <= w_count_next;
      if (w_push) begin
        r_buf_inst[r_tail] <= i_mem_rdata;
        r_buf_pc[r_tail]   <= r_mem_addr;
      end
      if (w_head_load) begin
        r_if_inst <= w_head_inst;
        r_if_pc   <= w_head_pc;
      end

      unique case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_state    <= StWait;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_fetch_pc_next;
          end
        end
        StWait: begin
          if (!i_mem_ack) begin
            // Read stays outstanding; a redirect marks its data for discard.
            if (i_redirect_valid) r_discard <= 1'b1;
          end else begin
            r_discard <= 1'b0;
            if (w_issue) begin
              r_mem_addr <= w_fetch_pc_next;
            end else begin
              r_state   <= StIdle;
              r_mem_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= StIdle;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_if_valid = (r_count != '0);
  assign o_if_inst  = r_if_inst;
  assign o_if_pc    = r_if_pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: memory returns addr ^ 16'hA5A5, either acking
// as soon as a request is visible (auto mode) or under direct step control.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        if_valid;
  logic [15:0] if_inst;
  logic [15:0] if_pc;
  logic        if_ready;

  logic        ack_auto;
  logic        ack_man;

  int n_vec;
  int n_err;

  assign mem_ack   = ack_auto ? mem_req : ack_man;
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  inst_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_halt           (halt),
    .i_redirect_valid (redirect_valid),
    .i_redirect_addr  (redirect_addr),
    .o_mem_req        (mem_req),
    .o_mem_addr       (mem_addr),
    .i_mem_ack        (mem_ack),
    .i_mem_rdata      (mem_rdata),
    .o_if_valid       (if_valid),
    .o_if_inst        (if_inst),
    .o_if_pc          (if_pc),
    .i_if_ready       (if_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [15:0] addr,
                         input logic vld);
    chk({tag, ".req"},   {15'd0, mem_req},  {15'd0, req});
    chk({tag, ".addr"},  mem_addr,          addr);
    chk({tag, ".valid"}, {15'd0, if_valid}, {15'd0, vld});
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc, input logic [15:0] inst);
    chk({tag, ".if_pc"},   if_pc,   pc);
    chk({tag, ".if_inst"}, if_inst, inst);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    ack_auto = 1'b0; ack_man = 1'b0; if_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk_out("reset", 1'b0, 16'h0000, 1'b0);
    chk_head("reset", 16'h0000, 16'h0000);

    // Streaming with immediate acks: one instruction per cycle
    rst = 1'b1; if_ready = 1'b1; ack_auto = 1'b1;
    tick(); chk_out("s1", 1'b1, 16'h0000, 1'b0);
    tick(); chk_out("s2", 1'b1, 16'h0002, 1'b1); chk_head("s2", 16'h0000, 16'hA5A5);
    tick(); chk_out("s3", 1'b1, 16'h0004, 1'b1); chk_head("s3", 16'h0002, 16'hA5A7);
    tick(); chk_out("s4", 1'b1, 16'h0006, 1'b1); chk_head("s4", 16'h0004, 16'hA5A1);

    // Backpressure: buffer fills to two entries, requests stop
    rst = 1'b0;
    tick(); chk_out("rst2", 1'b0, 16'h0000, 1'b0);
    rst = 1'b1; if_ready = 1'b0;
    tick(); chk_out("bp1", 1'b1, 16'h0000, 1'b0);
    tick(); chk_out("bp2", 1'b1, 16'h0002, 1'b1);
    tick(); chk_out("bp3", 1'b0, 16'h0002, 1'b1);
    tick(); chk_out("bp4", 1'b0, 16'h0002, 1'b1); chk_head("bp4", 16'h0000, 16'hA5A5);
    if_ready = 1'b1;
    tick(); chk_out("bp5", 1'b1, 16'h0004, 1'b1); chk_head("bp5", 16'h0002, 16'hA5A7);

    // Redirect during a delayed read: read held, its data discarded
    ack_auto = 1'b0; ack_man = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    tick(); chk_out("rd1", 1'b1, 16'h0004, 1'b0);
    redirect_valid = 1'b0;
    tick(); chk_out("rd2", 1'b1, 16'h0004, 1'b0);
    ack_man = 1'b1;
    tick(); chk_out("rd3", 1'b1, 16'h0100, 1'b0);
    tick(); chk_out("rd4", 1'b1, 16'h0102, 1'b1); chk_head("rd4", 16'h0100, 16'hA4A5);

    // Redirect on the same edge as ack and pop
    redirect_valid = 1'b1; redirect_addr = 16'h0200;
    tick(); chk_out("ra1", 1'b1, 16'h0200, 1'b0);
    redirect_valid = 1'b0; ack_man = 1'b0;

    // Move to PC 8, then halt with that read outstanding
    redirect_valid = 1'b1; redirect_addr = 16'h0008;
    tick(); chk_out("h0", 1'b1, 16'h0200, 1'b0);
    redirect_valid = 1'b0; ack_man = 1'b1;
    tick(); chk_out("h1", 1'b1, 16'h0008, 1'b0);
    ack_man = 1'b0; halt = 1'b1;
    tick(); chk_out("h2", 1'b1, 16'h0008, 1'b0);
    ack_man = 1'b1;
    tick(); chk_out("h3", 1'b0, 16'h0008, 1'b1); chk_head("h3", 16'h0008, 16'hA5AD);
    ack_man = 1'b0;
    tick(); chk_out("h4", 1'b0, 16'h0008, 1'b0); chk_head("h4", 16'h0008, 16'hA5AD);
    halt = 1'b0;
    tick(); chk_out("h5", 1'b1, 16'h000A, 1'b0);

    // Redirect near the top of the address space: PC wraps to zero
    redirect_valid = 1'b1; redirect_addr = 16'hFFFC; ack_auto = 1'b1;
    tick(); chk_out("w1", 1'b1, 16'hFFFC, 1'b0);
    redirect_valid = 1'b0;
    tick(); chk_out("w2", 1'b1, 16'hFFFE, 1'b1); chk_head("w2", 16'hFFFC, 16'h5A59);
    tick(); chk_out("w3", 1'b1, 16'h0000, 1'b1); chk_head("w3", 16'hFFFE, 16'h5A5B);

    // Reset mid-read, then a late ack that must be ignored
    ack_auto = 1'b0; ack_man = 1'b0; rst = 1'b0;
    tick(); chk_out("mr1", 1'b0, 16'h0000, 1'b0); chk_head("mr1", 16'h0000, 16'h0000);
    rst = 1'b1; ack_man = 1'b1;
    tick(); chk_out("mr2", 1'b1, 16'h0000, 1'b0);
    ack_man = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
